demux_1to2_buf: RTL and testbench
=================================

// Module: demux_1to2_buf
// PURPOSE
//  Buffered 1-to-2 stream demultiplexer: steers each word on one valid/ready input
//  channel to output 0 or 1 per select_i, with a per-output synchronous FIFO.
//  Inverse of the 2-to-1 datapath mux; sits between a producer stage (e.g. writeback
//  or memory-response path) and two independent consumers that stall separately.
// PARAMETERS
//  size   32  data width in bits
//  DEPTH  2   entries per output FIFO; power of 2, >= 2
// PORTS
//  clk_i      in   1           clock, all state on rising edge
//  rst_i      in   1           synchronous, active-high reset
//  data_i     in   size        input word
//  select_i   in   1           destination of data_i: 0 -> out0, 1 -> out1
//  valid_i    in   1           data_i/select_i valid
//  ready_o    out  1           block can accept this cycle
//  data0_o    out  size        head word of FIFO 0
//  valid0_o   out  1           FIFO 0 non-empty
//  ready0_i   in   1           consumer 0 takes head
//  data1_o    out  size        head word of FIFO 1
//  valid1_o   out  1           FIFO 1 non-empty
//  ready1_i   in   1           consumer 1 takes head
//  count0_o   out  clog2(DEPTH+1)  occupancy of FIFO 0
//  count1_o   out  clog2(DEPTH+1)  occupancy of FIFO 1
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): all pointers/counts 0, storage 0; after reset valid0_o=
//    valid1_o=0, data0_o=data1_o=0, count*_o=0. ready_o=0 while rst_i=1.
//  - Reset mid-operation: all buffered words discarded; no transfer on any channel
//    completes in a cycle with rst_i=1.
//  - Input transfer: valid_i & ready_o at edge. ready_o = !rst_i & !full[select_i]
//    (combinational on select_i). Producer holds data_i/select_i while valid_i & !ready_o.
//  - Full FIFO stalls input only when selected (head-of-line: a full FIFO 1 blocks a
//    word for 1; words for 0 still flow). No pass-through when full: ready_o=0 even if
//    the consumer pops that cycle.
//  - Output n transfer: validn_o & readyn_i at edge; head pointer advances.
//  - Latency: word accepted at edge k visible on datan_o/validn_o after edge k (earliest
//    pop at edge k+1). No combinational path data_i->datan_o.
//  - Outputs registered from storage; datan_o stable while validn_o & !readyn_i.
//  - Simultaneous push+pop on same FIFO (non-empty, non-full): count unchanged,
//    both pointers advance. Push+pop when empty: push only (pop invalid, valid=0).
//  - Pointers wrap mod DEPTH; count range 0..DEPTH; full = (count==DEPTH).
//  - Ordering: per-output FIFO order equals input acceptance order for that select.
//  - readyn_i while validn_o=0 is ignored.
// STRUCTURE
//  - No shared package types; pointer width clog2(DEPTH) and count width computed
//    locally via constant function.
//  - One sub-module, sync_fifo (params size, DEPTH; push/pop/full/empty/count/head),
//    instantiated twice; top holds only select steering and ready_o logic.
// TESTING
//  1 Reset: drive rst_i=1 2 cycles with valid_i=1 -> ready_o=0, valid*_o=0, counts 0.
//  2 Steering: push 0xA(sel0),0xB(sel1),0xC(sel0), readys=1 -> out0 gets A then C,
//    out1 gets B, each one cycle after acceptance.
//  3 Full/HOL: ready1_i=0, DEPTH=2, push 3 words sel1 -> 3rd held, ready_o=0,
//    count1_o=2; switching to sel0 word -> ready_o=1, accepted.
//  4 Simultaneous: FIFO0 count=1, push+pop same edge -> count0_o stays 1, order kept.
//  5 Wrap: stream 10 words sel0 with ready0_i toggling 1010... -> all 10 out in order.
//  6 Mid-op reset: count0_o=2,count1_o=1, assert rst_i 1 cycle -> all counts 0,
//    valid*_o=0, next pushed word emerges as first output.

Source files
------------

// File: rtl/demux_1to2_buf_pkg.sv
// Shared defaults and a width helper for the buffered 1-to-2 demultiplexer.
package demux_1to2_buf_pkg;

  localparam int DEF_SIZE  = 32;
  localparam int DEF_DEPTH = 2;

  // Bits needed to encode values 0..v-1.
  function automatic int clog2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head word is read straight from storage.
module sync_fifo
  import demux_1to2_buf_pkg::*;
#(
  parameter int size  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [size-1:0]               data_i,
  input  logic                          pop_i,
  output logic [size-1:0]               head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [clog2c(DEPTH+1)-1:0]    count_o
);

  localparam int PW = (clog2c(DEPTH) < 1) ? 1 : clog2c(DEPTH);
  localparam int CW = clog2c(DEPTH+1);

  logic [size-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // A push into a full FIFO or a pop from an empty one is dropped here, so callers
  // may drive raw handshakes.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 stream demultiplexer: steers each accepted word into one of two FIFOs.
module demux_1to2_buf
  import demux_1to2_buf_pkg::*;
#(
  parameter int size  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [size-1:0]               data_i,
  input  logic                          select_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [size-1:0]               data0_o,
  output logic                          valid0_o,
  input  logic                          ready0_i,
  output logic [size-1:0]               data1_o,
  output logic                          valid1_o,
  input  logic                          ready1_i,
  output logic [clog2c(DEPTH+1)-1:0]    count0_o,
  output logic [clog2c(DEPTH+1)-1:0]    count1_o
);

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_accept;
  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;

  // Only the selected FIFO can stall the input; a same-cycle pop never frees a full slot.
  assign ready_o  = ~rst_i & ~(select_i ? w_full1 : w_full0);
  assign w_accept = valid_i & ready_o;
  assign w_push0  = w_accept & ~select_i;
  assign w_push1  = w_accept & select_i;

  assign valid0_o = ~w_empty0;
  assign valid1_o = ~w_empty1;
  assign w_pop0   = valid0_o & ready0_i & ~rst_i;
  assign w_pop1   = valid1_o & ready1_i & ~rst_i;

  sync_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push0),
    .data_i  (data_i),
    .pop_i   (w_pop0),
    .head_o  (data0_o),
    .full_o  (w_full0),
    .empty_o (w_empty0),
    .count_o (count0_o)
  );

  sync_fifo #(.size(size), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push1),
    .data_i  (data_i),
    .pop_i   (w_pop1),
    .head_o  (data1_o),
    .full_o  (w_full1),
    .empty_o (w_empty1),
    .count_o (count1_o)
  );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: stimulus queues expected words, a monitor checks outputs.
module tb_demux_1to2_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o;
  logic        valid0_o;
  logic        ready0_i;
  logic [31:0] data1_o;
  logic        valid1_o;
  logic        ready1_i;
  logic [1:0]  count0_o;
  logic [1:0]  count1_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk_i = ~clk_i;

  demux_1to2_buf #(.size(32), .DEPTH(2)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count0_o (count0_o),
    .count1_o (count1_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake seen before the coming edge must match the queue head.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (valid0_o && ready0_i) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out0_unexpected: got %0h expected none", data0_o);
        end else chk("out0_data", data0_o, q0.pop_front());
      end
      if (valid1_o && ready1_i) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out1_unexpected: got %0h expected none", data1_o);
        end else chk("out1_data", data1_o, q1.pop_front());
      end
    end
  end

  // Issue one word; returns just after the accepting edge.
  task automatic push(input logic [31:0] d, input logic sel);
    bit ok;
    ok = 1'b0;
    data_i = d; select_i = sel; valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (ready_o) begin
        if (sel) q1.push_back(d); else q0.push_back(d);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got no ready expected ready for %0h", d);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk_i);
    end
    @(posedge clk_i); #1;
    chk("drain_left", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; data_i = 32'h0; select_i = 1'b0; valid_i = 1'b1;
    ready0_i = 1'b1; ready1_i = 1'b1;

    // 1 reset with valid held high
    @(negedge clk_i);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_ready2", {31'd0, ready_o}, 32'd0);
    chk("rst_valid0", {31'd0, valid0_o}, 32'd0);
    chk("rst_valid1", {31'd0, valid1_o}, 32'd0);
    chk("rst_count0", {30'd0, count0_o}, 32'd0);
    chk("rst_count1", {30'd0, count1_o}, 32'd0);
    chk("rst_data0", data0_o, 32'd0);
    chk("rst_data1", data1_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0;

    // 2 steering, visible one cycle after acceptance
    push(32'hA, 1'b0);
    @(negedge clk_i);
    chk("lat_valid0", {31'd0, valid0_o}, 32'd1);
    @(posedge clk_i); #1;
    push(32'hB, 1'b1);
    @(negedge clk_i);
    chk("lat_valid1", {31'd0, valid1_o}, 32'd1);
    @(posedge clk_i); #1;
    push(32'hC, 1'b0);
    drain();

    // 3 full FIFO 1 blocks only words for 1
    ready1_i = 1'b0;
    push(32'h11, 1'b1);
    push(32'h12, 1'b1);
    data_i = 32'h13; select_i = 1'b1; valid_i = 1'b1;
    @(negedge clk_i);
    chk("hol_ready", {31'd0, ready_o}, 32'd0);
    chk("hol_count1", {30'd0, count1_o}, 32'd2);
    @(posedge clk_i); #1;
    chk("hol_count1_held", {30'd0, count1_o}, 32'd2);
    push(32'h20, 1'b0);
    ready1_i = 1'b1;
    drain();

    // 4 simultaneous push and pop on FIFO 0
    ready0_i = 1'b0;
    push(32'h31, 1'b0);
    chk("sim_count_pre", {30'd0, count0_o}, 32'd1);
    ready0_i = 1'b1;
    push(32'h32, 1'b0);
    ready0_i = 1'b0;
    chk("sim_count_post", {30'd0, count0_o}, 32'd1);
    ready0_i = 1'b1;
    drain();

    // 5 pointer wrap under a toggling consumer
    fork
      begin
        for (int i = 0; i < 10; i++) push(32'h50 + 32'(i), 1'b0);
      end
      begin
        repeat (40) begin
          @(posedge clk_i); #1;
          ready0_i = ~ready0_i;
        end
      end
    join
    ready0_i = 1'b1;
    drain();

    // 6 reset mid-operation discards buffered words
    ready0_i = 1'b0; ready1_i = 1'b0;
    push(32'h61, 1'b0);
    push(32'h62, 1'b0);
    push(32'h71, 1'b1);
    chk("mid_count0", {30'd0, count0_o}, 32'd2);
    chk("mid_count1", {30'd0, count1_o}, 32'd1);
    rst_i = 1'b1; data_i = 32'h99; select_i = 1'b1; valid_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    q0.delete(); q1.delete();
    chk("mid_count0_clr", {30'd0, count0_o}, 32'd0);
    chk("mid_count1_clr", {30'd0, count1_o}, 32'd0);
    chk("mid_valid0_clr", {31'd0, valid0_o}, 32'd0);
    chk("mid_valid1_clr", {31'd0, valid1_o}, 32'd0);
    ready0_i = 1'b1; ready1_i = 1'b1;
    push(32'h81, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
